// File: rtl/acc_control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator machine (PC, IR, AC).
// Define ACC_SEQ_ILLEGAL_TRAP_EN to make illegal opcodes halt with error set.
module acc_control_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        halted,
   output logic        error,
   output logic [15:0] pc_out,
   output logic [15:0] acc_out,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   input  logic [15:0] mem_rdata,
   output logic [3:0]  alu_opcode,
   output logic [15:0] alu_operand1,
   output logic [15:0] alu_operand2,
   input  logic [15:0] alu_result
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD_IR, S_EXEC, S_WRITEBACK, S_HALT
   } state_t;

   localparam logic [3:0] OP_HALT  = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_JUMP  = 4'h3;
   localparam logic [3:0] OP_JZ    = 4'h4;
   localparam logic [3:0] OP_ALU   = 4'h5;

   state_t      state, state_nx;
   logic [15:0] pc, pc_nx, ir, ir_nx, ac, ac_nx;
   logic [3:0]  opcode;
   logic [15:0] op_addr, alu_addr;

   assign opcode   = ir[15:12];
   assign op_addr  = {4'h0, ir[11:0]};
   assign alu_addr = {8'h00, ir[7:0]};

   assign halted       = (state == S_HALT);
   assign pc_out       = pc;
   assign acc_out      = ac;
   assign mem_wdata    = ac;
   assign alu_operand1 = ac;
   assign alu_operand2 = mem_rdata;

`ifdef ACC_SEQ_ILLEGAL_TRAP_EN
   logic err_q, err_set;
   assign error = err_q;
`else
   assign error = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
         ir    <= 16'h0000;
         ac    <= 16'h0000;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         ir    <= ir_nx;
         ac    <= ac_nx;
      end
   end

`ifdef ACC_SEQ_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end
`endif

   // mem_we is purely combinational on state, so an async reset kills a STORE at once
   always_comb begin
      state_nx   = state;
      pc_nx      = pc;
      ir_nx      = ir;
      ac_nx      = ac;
      mem_addr   = pc;
      mem_we     = 1'b0;
      alu_opcode = 4'b0000;
`ifdef ACC_SEQ_ILLEGAL_TRAP_EN
      err_set    = 1'b0;
`endif
      case (state)
         S_IDLE:    if (start) state_nx = S_FETCH;
         S_FETCH:   state_nx = S_LOAD_IR;
         S_LOAD_IR: begin
            ir_nx    = mem_rdata;
            pc_nx    = pc + 16'd1;
            state_nx = S_EXEC;
         end
         S_EXEC: begin
            mem_addr = (opcode == OP_ALU) ? alu_addr : op_addr;
            case (opcode)
               OP_HALT:  state_nx = S_HALT;
               OP_LOAD:  state_nx = S_WRITEBACK;
               OP_ALU:   state_nx = S_WRITEBACK;
               OP_STORE: begin
                  mem_we   = 1'b1;
                  state_nx = S_FETCH;
               end
               OP_JUMP: begin
                  pc_nx    = op_addr;
                  state_nx = S_FETCH;
               end
               OP_JZ: begin
                  if (ac == 16'h0000) pc_nx = op_addr;
                  state_nx = S_FETCH;
               end
               default: begin
`ifdef ACC_SEQ_ILLEGAL_TRAP_EN
                  err_set  = 1'b1;
                  state_nx = S_HALT;
`else
                  state_nx = S_FETCH;
`endif
               end
            endcase
         end
         S_WRITEBACK: begin
            if (opcode == OP_ALU) begin
               alu_opcode = ir[11:8];
               ac_nx      = alu_result;
            end else begin
               ac_nx      = mem_rdata;
            end
            state_nx = S_FETCH;
         end
         S_HALT:  state_nx = S_HALT;
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_acc_control_sequencer.sv
// Bench for acc_control_sequencer: directed program tests plus random programs
// checked against an instruction-level model, with a bench-side memory and ALU.
module tb_acc_control_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        halted, error, mem_we;
   logic [15:0] pc_out, acc_out, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  alu_opcode;
   logic [15:0] alu_operand1, alu_operand2, alu_result;

   logic        halted2, error2, mem_we2;
   logic [15:0] pc2, acc2, mem_addr2, mem_wdata2, mem_rdata2;
   logic [3:0]  alu_opcode2;
   logic [15:0] alu_op1_2, alu_op2_2, alu_result2;

   logic        ld_en = 1'b0;
   logic [15:0] ld_addr = 16'h0, ld_data = 16'h0;
   logic [15:0] mem  [0:65535];
   logic [15:0] mem2 [0:65535];
   logic [15:0] mm   [0:255];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      case (f)
         4'h0:    return a + b;
         4'h1:    return a - b;
         4'h2:    return a & b;
         4'h3:    return a | b;
         4'h4:    return a ^ b;
         default: return b;
      endcase
   endfunction

   assign alu_result  = alu_fn(alu_opcode, alu_operand1, alu_operand2);
   assign alu_result2 = alu_fn(alu_opcode2, alu_op1_2, alu_op2_2);

   always @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr]  <= ld_data;
         mem2[ld_addr] <= ld_data;
      end else begin
         if (mem_we)  mem[mem_addr]   <= mem_wdata;
         if (mem_we2) mem2[mem_addr2] <= mem_wdata2;
      end
      mem_rdata  <= mem[mem_addr];
      mem_rdata2 <= mem2[mem_addr2];
   end

   acc_control_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .halted(halted), .error(error),
      .pc_out(pc_out), .acc_out(acc_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata), .alu_opcode(alu_opcode),
      .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_result(alu_result));

   acc_control_sequencer #(.RESET_PC(16'hFFFF)) u_wrap (
      .clk(clk), .reset(reset), .start(start), .halted(halted2), .error(error2),
      .pc_out(pc2), .acc_out(acc2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_we(mem_we2), .mem_rdata(mem_rdata2), .alu_opcode(alu_opcode2),
      .alu_operand1(alu_op1_2), .alu_operand2(alu_op2_2), .alu_result(alu_result2));

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic hold_reset();
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic go();
      reset = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] m_pc, m_ac, ins, a;
      logic [3:0]  op;
      int          ncyc;
      logic        we_seen;

      // reset state and idle
      hold_reset();
      chk("rst_pc", pc_out, 16'h0000);
      chk("rst_acc", acc_out, 16'h0000);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_we", {15'h0, mem_we}, 16'h0);
      chk("rst_halted", {15'h0, halted}, 16'h0);
      chk("rst_error", {15'h0, error}, 16'h0);
      chk("rst_aluop", {12'h0, alu_opcode}, 16'h0);
      chk("rst_wrap_pc", pc2, 16'hFFFF);
      reset = 1'b0;
      we_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_we) we_seen = 1'b1;
      end
      #1;
      chk("idle_we", {15'h0, we_seen}, 16'h0);
      chk("idle_pc", pc_out, 16'h0000);
      chk("idle_halted", {15'h0, halted}, 16'h0);

      // basic program: LOAD, ALUOP add, STORE, HALT
      hold_reset();
      wr(16'h0000, 16'h1010); wr(16'h0001, 16'h5011);
      wr(16'h0002, 16'h2012); wr(16'h0003, 16'h0000);
      wr(16'h0010, 16'd5);    wr(16'h0011, 16'd7);  wr(16'h0012, 16'h0000);
      go();
      cyc(13);
      chk("basic_not_halted_13", {15'h0, halted}, 16'h0);
      cyc(1);
      chk("basic_halted_14", {15'h0, halted}, 16'h1);
      chk("basic_acc", acc_out, 16'd12);
      chk("basic_mem12", mem[16'h0012], 16'd12);
      chk("basic_pc", pc_out, 16'h0004);
      chk("basic_wdata", mem_wdata, 16'd12);
      start = 1'b1; cyc(1); start = 1'b0; cyc(3);
      chk("halt_start_ignored", {15'h0, halted}, 16'h1);
      chk("halt_pc_hold", pc_out, 16'h0004);

      // branches: taken with AC=0, not taken with AC=3
      hold_reset();
      wr(16'h0000, 16'h4020); wr(16'h0020, 16'h1030);
      wr(16'h0021, 16'h4020); wr(16'h0030, 16'd3);
      go();
      cyc(3);
      chk("jz_taken_pc", pc_out, 16'h0020);
      cyc(4);
      chk("jz_load_acc", acc_out, 16'd3);
      cyc(3);
      chk("jz_not_taken_pc", pc_out, 16'h0022);

      // PC wrap on the RESET_PC=FFFF instance
      hold_reset();
      wr(16'hFFFF, 16'h3005);
      go();
      cyc(2);
      chk("wrap_pc_zero", pc2, 16'h0000);
      cyc(1);
      chk("wrap_pc_jump", pc2, 16'h0005);

      // illegal opcode
      hold_reset();
      wr(16'h0000, 16'h7000); wr(16'h0001, 16'h0000);
      go();
      cyc(3);
`ifdef ACC_SEQ_ILLEGAL_TRAP_EN
      chk("ill_halted", {15'h0, halted}, 16'h1);
      chk("ill_error", {15'h0, error}, 16'h1);
`else
      chk("ill_halted", {15'h0, halted}, 16'h0);
      chk("ill_error", {15'h0, error}, 16'h0);
      chk("ill_pc", pc_out, 16'h0001);
      cyc(3);
      chk("ill_then_halt", {15'h0, halted}, 16'h1);
`endif

      // reset during EXEC of a STORE
      hold_reset();
      wr(16'h0000, 16'h2050); wr(16'h0050, 16'hBEEF);
      go();
      cyc(2);
      chk("st_exec_we", {15'h0, mem_we}, 16'h1);
      chk("st_exec_addr", mem_addr, 16'h0050);
      reset = 1'b1; #1;
      chk("st_reset_we", {15'h0, mem_we}, 16'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("st_mem_unchanged", mem[16'h0050], 16'hBEEF);
      cyc(3);
      chk("st_idle_pc", pc_out, 16'h0000);
      chk("st_idle_addr", mem_addr, 16'h0000);
      chk("st_idle_halted", {15'h0, halted}, 16'h0);

      // random programs against an instruction-level model
      for (int it = 0; it < 6; it++) begin
         hold_reset();
         for (int i = 0; i < 32; i++) begin
            case ($urandom_range(0, 4))
               0:       ins = {4'h1, 12'h040 + 12'($urandom_range(0, 31))};
               1:       ins = {4'h2, 12'h040 + 12'($urandom_range(0, 31))};
               2:       ins = {4'h3, 12'($urandom_range(0, 30))};
               3:       ins = {4'h4, 12'($urandom_range(0, 30))};
               default: ins = {4'h5, 4'($urandom_range(0, 5)), 8'h40 + 8'($urandom_range(0, 31))};
            endcase
            if (i == 31) ins = {4'h3, 12'($urandom_range(0, 30))};
            mm[i] = ins;
            wr(16'(i), ins);
         end
         for (int i = 64; i < 96; i++) begin
            mm[i] = 16'($urandom);
            wr(16'(i), mm[i]);
         end
         go();
         m_pc = 16'h0; m_ac = 16'h0;
         for (int k = 0; k < 30; k++) begin
            ins  = mm[m_pc[7:0]];
            op   = ins[15:12];
            a    = (op == 4'h5) ? {8'h0, ins[7:0]} : {4'h0, ins[11:0]};
            m_pc = m_pc + 16'd1;
            ncyc = 3;
            case (op)
               4'h1: begin m_ac = mm[a[7:0]]; ncyc = 4; end
               4'h2: mm[a[7:0]] = m_ac;
               4'h3: m_pc = a;
               4'h4: if (m_ac == 16'h0) m_pc = a;
               4'h5: begin m_ac = alu_fn(ins[11:8], m_ac, mm[a[7:0]]); ncyc = 4; end
               default: ;
            endcase
            cyc(ncyc);
            chk($sformatf("rnd%0d_pc%0d", it, k), pc_out, m_pc);
            chk($sformatf("rnd%0d_acc%0d", it, k), acc_out, m_ac);
         end
         for (int i = 64; i < 96; i++)
            chk($sformatf("rnd%0d_mem%0h", it, i), mem[i], mm[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/acc_control_sequencer.md
# acc_control_sequencer

Fetch/decode/execute controller for the 16-bit accumulator machine. It holds the architectural state: program counter, instruction register and accumulator. It sequences `MainMemory` through its address, write-data and write-enable ports, and drives the `ALU` opcode and operands. It sits between the two, feeding both and consuming their outputs. `Computer` instantiates one sequencer, one `ALU` and one `MainMemory` and wires them directly.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; forces IDLE and all registers to their reset values.
- `start` input, 1 bit: one-cycle request to begin execution; sampled only in IDLE.
- `halted` output, 1 bit: high in HALT.
- `error` output, 1 bit: high when HALT was entered through an illegal opcode (trap build only).
- `pc_out` output, 16 bits: current PC (debug).
- `acc_out` output, 16 bits: current accumulator (debug).
- `mem_addr` output, 16 bits: address to `MainMemory.addr`.
- `mem_wdata` output, 16 bits: always equals AC; to `MainMemory.data_in`.
- `mem_we` output, 1 bit: to `MainMemory.write_enable`.
- `mem_rdata` input, 16 bits: from `MainMemory.data_out`; registered, valid one edge after the address.
- `alu_opcode` output, 4 bits: ALU function.
- `alu_operand1` output, 16 bits: always AC.
- `alu_operand2` output, 16 bits: always `mem_rdata`.
- `alu_result` input, 16 bits: combinational ALU result.

## Operation
- Instruction word: opcode = IR[15:12], operand = IR[11:0].
  - Operand address is IR[11:0] zero-extended to 16 bits.
  - For ALUOP only: function = IR[11:8] and address = IR[7:0] zero-extended.
- Opcodes:
  - 0x0 HALT.
  - 0x1 LOAD: AC←M[a].
  - 0x2 STORE: M[a]←AC.
  - 0x3 JUMP: PC←a.
  - 0x4 JZ: PC←a if AC==0.
  - 0x5 ALUOP: AC←ALU(f, AC, M[a]).
  - 0x6–0xF: illegal.
- States: IDLE, FETCH, LOAD_IR, EXEC, WRITEBACK, HALT.
  - IDLE: `mem_addr`=PC. On `start`=1 go to FETCH; otherwise stay.
  - FETCH: `mem_addr`=PC, `mem_we`=0. Go to LOAD_IR.
  - LOAD_IR: IR←`mem_rdata`; PC←PC+1, wrapping 16'hFFFF→16'h0000. Go to EXEC.
  - EXEC: `mem_addr`=operand address.
    - STORE: `mem_we`=1 for this cycle only, then FETCH.
    - JUMP, or JZ taken: PC←a, then FETCH.
    - JZ not taken: FETCH.
    - LOAD, ALUOP: go to WRITEBACK.
    - HALT: go to HALT.
    - Illegal: see Configuration.
  - WRITEBACK: `mem_rdata` holds M[a].
    - LOAD: AC←`mem_rdata`.
    - ALUOP: AC←`alu_result`, with `alu_opcode`=f.
    - Then go to FETCH.
  - HALT: `halted`=1; no memory writes. Only `reset` exits HALT; `start` is ignored.
- `alu_opcode` is IR[11:8] in WRITEBACK and 4'b0000 in every other state.
- `mem_addr` is PC in every state except EXEC.
- Division by zero is not guarded here; the ALU output is taken as-is.

## Timing
- Reset values: state=IDLE, PC=`RESET_PC`, IR=0, AC=0, `halted`=0, `error`=0, `mem_we`=0, `mem_addr`=`RESET_PC`, `alu_opcode`=0.
- Cycles per instruction: LOAD and ALUOP take 4 (FETCH, LOAD_IR, EXEC, WRITEBACK); STORE, JUMP and JZ take 3.
- The first FETCH occurs in the cycle after `start` is sampled.
- `start` asserted outside IDLE has no effect.
- Reset asserted mid-instruction: `mem_we` drops immediately (asynchronous) and any STORE in EXEC is aborted.
- A STORE followed by a LOAD of the same address returns the new value; the memory write completes before the next read address is presented.
- Self-modifying code is legal and takes effect on the next fetch.

## Configuration
- `ACC_SEQ_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in EXEC goes to HALT with `error`=1.
  - `error` stays high until reset.
- Macro undefined:
  - An illegal opcode executes as a 3-cycle NOP (EXEC→FETCH).
  - `error` is tied to 0.

## Test plan
- Reset then idle: hold `start`=0 for 10 cycles → PC=0, `mem_we` never asserted, `halted`=0.
- Basic program: M[0]=0x1010 (LOAD 0x10), M[1]=0x5011 (ALUOP add 0x11), M[2]=0x2012 (STORE 0x12), M[3]=0x0000 (HALT); M[0x10]=5, M[0x11]=7; pulse `start`.
  - Required: M[0x12]=12, AC=12, `halted`=1.
  - Required: `halted` rises exactly 4+4+3+3 cycles after the first FETCH.
- Branches: AC=0 followed by JZ 0x020 → PC=0x020; AC=3 followed by JZ 0x020 → PC = JZ address+1.
- Wrap: `RESET_PC`=16'hFFFF with a JUMP 0x005 at 0xFFFF → PC reads 0x0000 after LOAD_IR, then 0x005.
- Illegal opcode: M[0]=0x7000 → with `ACC_SEQ_ILLEGAL_TRAP_EN`, `halted`=1 and `error`=1 after 3 cycles; without it, execution continues at PC=1.
- Reset during EXEC of a STORE → `mem_we` falls the same cycle, the target word is unchanged, and state returns to IDLE with PC=`RESET_PC`.
